// File: rtl/dot_mac_pkg.sv
// mac_pkg: shared Q-format defaults, width helpers and output rounding/saturation for dot_mac.
package mac_pkg;
    localparam int Q_WIDTH = 16;
    localparam int Q_FRAC = 10;
    localparam int Q_LANES = 4;
    localparam int ACC_MAX = 128;

    typedef struct packed {
        logic signed [63:0] val;
        logic sat;
    } rs_t;

    function automatic int sum_w(input int pw, input int lanes);
        return pw + $clog2(lanes);
    endfunction

    // Floor after optional half-up bias, then clip to a signed width-bit range.
    function automatic rs_t round_sat(input logic signed [ACC_MAX-1:0] acc, input int frac, input int width, input logic rnd);
        logic signed [ACC_MAX-1:0] r, hi, lo;
        rs_t rs;
        r = (acc + (rnd ? ACC_MAX'(1) <<< (frac - 1) : ACC_MAX'(0))) >>> frac;
        hi = (ACC_MAX'(1) <<< (width - 1)) - ACC_MAX'(1);
        lo = -(ACC_MAX'(1) <<< (width - 1));
        rs.sat = r > hi || r < lo;
        rs.val = 64'(r > hi ? hi : r < lo ? lo : r);
        return rs;
    endfunction
endpackage

// File: rtl/dot_mac_if.sv
// dot_mac_if: beat input stream and result output stream of the dot-product engine.
interface dot_mac_if import mac_pkg::*; #(parameter int WIDTH = Q_WIDTH, parameter int LANES = Q_LANES);
    logic in_valid, in_ready, in_first, in_last;
    logic [LANES*WIDTH-1:0] a, b;
    logic [WIDTH-1:0] bias;
    logic out_valid, out_ready, out_sat;
    logic [WIDTH-1:0] out_data;
    logic [15:0] out_beats;
    modport master(output in_valid, in_first, in_last, a, b, bias, out_ready,
                   input in_ready, out_valid, out_data, out_sat, out_beats);
    modport slave(input in_valid, in_first, in_last, a, b, bias, out_ready,
                  output in_ready, out_valid, out_data, out_sat, out_beats);
endinterface

// File: rtl/dot_mac_adder_tree.sv
// mac_adder_tree: registered sign-extending sum of LANES packed signed inputs.
module mac_adder_tree import mac_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int LANES = Q_LANES
) (
    input logic clk,
    input logic rst,
    input logic en,
    input logic [LANES*WIDTH-1:0] p,
    output logic signed [sum_w(WIDTH, LANES)-1:0] sum
);
    localparam int OW = sum_w(WIDTH, LANES);
    logic signed [OW-1:0] s;
    always_comb begin
        s = '0;
        for (int i = 0; i < LANES; i++) s = s + OW'($signed(p[i*WIDTH +: WIDTH]));
    end
    always_ff @(posedge clk)
        if (rst) sum <= '0;
        else if (en) sum <= s;
endmodule

// File: rtl/dot_mac.sv
// dot_mac: multi-lane fixed-point dot product with biased framed accumulation and rounded/saturated output.
module dot_mac import mac_pkg::*; #(
    parameter int WIDTH = Q_WIDTH,
    parameter int FRAC = Q_FRAC,
    parameter int LANES = Q_LANES,
    parameter int ACC_WIDTH = 40,
    parameter int RND = 1
) (
    input logic clk,
    input logic rst,
    dot_mac_if.slave io
);
    localparam int PW = 2 * WIDTH;
    localparam int SW = sum_w(PW, LANES);
    logic adv, done;
    logic s1_v, s1_f, s1_l, s2_v, s2_f, s2_l, s3_v, s3_f, s3_l, s4_v, s4_l;
    logic [LANES*WIDTH-1:0] s1_a, s1_b;
    logic signed [WIDTH-1:0] s1_bias, s2_bias, s3_bias;
    logic [LANES*PW-1:0] s2_p;
    logic signed [SW-1:0] s3_sum;
    logic signed [ACC_WIDTH-1:0] acc, acc_base, acc_n;
    logic [15:0] cnt, cnt_n;
    rs_t rs;
    assign adv = !io.out_valid || io.out_ready;
    assign io.in_ready = adv;
    assign done = s4_v && s4_l;
    // A finished vector leaves S4 this edge, so a following non-first beat starts from zero.
    always_comb begin
        acc_base = s3_f ? ACC_WIDTH'(s3_bias) <<< FRAC : done ? '0 : acc;
        acc_n = s3_v ? acc_base + ACC_WIDTH'(s3_sum) : done ? '0 : acc;
        cnt_n = s3_v ? (s3_f || done ? 16'd1 : cnt + 16'(cnt != 16'hffff)) : done ? '0 : cnt;
        rs = round_sat(ACC_MAX'(acc), FRAC, WIDTH, RND != 0);
    end
    mac_adder_tree #(.WIDTH(PW), .LANES(LANES)) u_tree (
        .clk(clk), .rst(rst), .en(adv), .p(s2_p), .sum(s3_sum)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            {s1_v, s2_v, s3_v, s4_v, s4_l} <= '0;
            acc <= '0;
            cnt <= '0;
            io.out_valid <= 1'b0;
            io.out_data <= '0;
            io.out_sat <= 1'b0;
            io.out_beats <= '0;
        end else if (adv) begin
            s1_v <= io.in_valid;
            s2_v <= s1_v;
            s3_v <= s2_v;
            s4_v <= s3_v;
            s4_l <= s3_l;
            acc <= acc_n;
            cnt <= cnt_n;
            io.out_valid <= done;
            if (done) begin
                io.out_data <= rs.val[WIDTH-1:0];
                io.out_sat <= rs.sat;
                io.out_beats <= cnt;
            end
        end
    end
    always_ff @(posedge clk)
        if (adv) begin
            s1_f <= io.in_first;
            s1_l <= io.in_last;
            s1_a <= io.a;
            s1_b <= io.b;
            s1_bias <= io.bias;
            {s2_f, s2_l, s2_bias} <= {s1_f, s1_l, s1_bias};
            {s3_f, s3_l, s3_bias} <= {s2_f, s2_l, s2_bias};
            for (int i = 0; i < LANES; i++)
                s2_p[i*PW +: PW] <= $signed(s1_a[i*WIDTH +: WIDTH]) * $signed(s1_b[i*WIDTH +: WIDTH]);
        end
endmodule

// File: tb/tb_dot_mac.sv
// tb_dot_mac: randomized scoreboard bench for dot_mac (RND=1 and RND=0 instances share stimulus).
module tb_dot_mac;
    import mac_pkg::*;
    localparam int W = 16;
    localparam int L = 4;

    typedef struct {
        longint data;
        longint sat;
        longint beats;
    } exp_t;

    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;

    dot_mac_if #(.WIDTH(W), .LANES(L)) io0 ();
    dot_mac_if #(.WIDTH(W), .LANES(L)) io1 ();

    dot_mac #(.WIDTH(W), .FRAC(10), .LANES(L), .ACC_WIDTH(40), .RND(1)) dut0 (.clk(clk), .rst(rst), .io(io0.slave));
    dot_mac #(.WIDTH(W), .FRAC(10), .LANES(L), .ACC_WIDTH(40), .RND(0)) dut1 (.clk(clk), .rst(rst), .io(io1.slave));

    assign io1.in_valid = io0.in_valid;
    assign io1.in_first = io0.in_first;
    assign io1.in_last = io0.in_last;
    assign io1.a = io0.a;
    assign io1.b = io0.b;
    assign io1.bias = io0.bias;
    assign io1.out_ready = io0.out_ready;

    exp_t q0[$], q1[$];
    exp_t e0, e1;
    int checks = 0, passes = 0;
    int n_out0 = 0, stalls = 0, rdy_mode = 0;
    longint macc = 0, mcnt = 0, hd0 = 0, last_d0 = 0, last_b0 = 0;
    bit held0 = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic longint fdiv(input longint x);
        return x >= 0 ? x / 1024 : -((-x + 1023) / 1024);
    endfunction

    function automatic exp_t mk(input bit rnd);
        longint r;
        exp_t e;
        r = fdiv(macc + (rnd ? 512 : 0));
        e.sat = (r > 32767 || r < -32768) ? 1 : 0;
        e.data = r > 32767 ? 32767 : r < -32768 ? -32768 : r;
        e.beats = mcnt > 65535 ? 65535 : mcnt;
        return e;
    endfunction

    function automatic logic [L*W-1:0] rep(input logic [W-1:0] x);
        return {L{x}};
    endfunction

    // Reference model: a beat is taken at the coming edge when valid and ready hold at the negedge.
    always @(negedge clk) begin : model
        longint s;
        if (rst) begin
            macc = 0;
            mcnt = 0;
            q0.delete();
            q1.delete();
        end else if (io0.in_valid && io0.in_ready) begin
            s = 0;
            for (int i = 0; i < L; i++)
                s += longint'($signed(io0.a[i*W +: W])) * longint'($signed(io0.b[i*W +: W]));
            if (io0.in_first) begin
                macc = longint'($signed(io0.bias)) * 1024 + s;
                mcnt = 1;
            end else begin
                macc += s;
                mcnt++;
            end
            if (io0.in_last) begin
                q0.push_back(mk(1));
                q1.push_back(mk(0));
                macc = 0;
                mcnt = 0;
            end
        end
    end

    always @(negedge clk) begin : mon0
        if (rst) held0 = 0;
        else begin
            if (held0) begin
                chk("hold_valid", io0.out_valid, 1);
                chk("hold_data", $signed(io0.out_data), hd0);
            end
            held0 = io0.out_valid && !io0.out_ready;
            hd0 = $signed(io0.out_data);
            chk("in_ready", io0.in_ready, !(io0.out_valid && !io0.out_ready));
            if (!io0.in_ready) stalls++;
            if (io0.out_valid && io0.out_ready) begin
                n_out0++;
                last_d0 = $signed(io0.out_data);
                last_b0 = io0.out_beats;
                if (q0.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_out0: got %0d expected none", $signed(io0.out_data));
                end else begin
                    e0 = q0.pop_front();
                    chk("data_rnd1", $signed(io0.out_data), e0.data);
                    chk("sat_rnd1", io0.out_sat, e0.sat);
                    chk("beats_rnd1", io0.out_beats, e0.beats);
                end
            end
        end
    end

    always @(negedge clk) begin : mon1
        if (!rst && io1.out_valid && io1.out_ready) begin
            if (q1.size() == 0) begin
                checks++;
                $display("FAIL unexpected_out1: got %0d expected none", $signed(io1.out_data));
            end else begin
                e1 = q1.pop_front();
                chk("data_rnd0", $signed(io1.out_data), e1.data);
                chk("sat_rnd0", io1.out_sat, e1.sat);
                chk("beats_rnd0", io1.out_beats, e1.beats);
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        io0.out_ready = rdy_mode == 2 ? 1'b0 : rdy_mode == 1 ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    task automatic send(input bit f, input bit l, input logic [L*W-1:0] av, input logic [L*W-1:0] bv, input logic [W-1:0] bi);
        int n = 0;
        bit ok = 0;
        io0.in_valid = 1;
        io0.in_first = f;
        io0.in_last = l;
        io0.a = av;
        io0.b = bv;
        io0.bias = bi;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = io0.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) begin
            checks++;
            $display("FAIL send_timeout: got %0d cycles expected accept", n);
        end
    endtask

    task automatic idle(input int n);
        io0.in_valid = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int n, base;
        io0.in_valid = 0;
        io0.in_first = 0;
        io0.in_last = 0;
        io0.a = '0;
        io0.b = '0;
        io0.bias = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", io0.out_valid, 0);
        chk("rst_out_data", io0.out_data, 0);
        chk("rst_out_sat", io0.out_sat, 0);
        chk("rst_out_beats", io0.out_beats, 0);
        chk("rst_in_ready", io0.in_ready, 1);
        rst = 0;
        idle(2);

        send(1, 1, rep(16'd1024), rep(16'd2048), 16'd0);
        io0.in_valid = 0;
        n = 0;
        while (!io0.out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", n, 4);
        chk("single_data", $signed(io0.out_data), 8192);
        idle(6);

        send(1, 0, rep(16'd1536), rep(16'hFE00), 16'd1024);
        send(0, 0, rep(16'd1536), rep(16'hFE00), 16'd0);
        send(0, 1, rep(16'd1536), rep(16'hFE00), 16'd0);
        send(1, 1, rep(16'd31744), rep(16'd31744), 16'd0);
        send(1, 1, rep(16'd31744), rep(16'h8400), 16'd0);
        send(1, 1, {48'd0, 16'd1}, {48'd0, 16'd512}, 16'd0);
        send(1, 1, {48'd0, 16'hFFFF}, {48'd0, 16'd512}, 16'd0);
        idle(10);

        fork
            for (int i = 0; i < 10; i++) send(1, 1, {$urandom, $urandom}, {$urandom, $urandom}, 16'($urandom));
            begin
                repeat (3) @(posedge clk);
                rdy_mode = 2;
                repeat (6) @(posedge clk);
                rdy_mode = 0;
            end
        join
        idle(10);
        chk("stall_seen", stalls > 0, 1);

        rdy_mode = 1;
        for (int v = 0; v < 30; v++) begin
            int len;
            len = $urandom_range(1, 5);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) idle(1);
                send(k == 0 && $urandom_range(0, 7) != 0, k == len - 1,
                     {$urandom, $urandom}, {$urandom, $urandom}, 16'($urandom));
            end
        end
        rdy_mode = 0;
        idle(20);

        send(1, 1, rep(16'd700), rep(16'd900), 16'd5);
        send(1, 0, rep(16'd1024), rep(16'd1024), 16'd0);
        io0.in_first = 0;
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        io0.in_valid = 0;
        base = n_out0;
        send(1, 1, {48'd0, 16'd1024}, {48'd0, 16'd1024}, 16'd0);
        idle(12);
        chk("post_rst_count", n_out0 - base, 1);
        chk("post_rst_data", last_d0, 1024);
        chk("post_rst_beats", last_b0, 1);
        chk("q_rnd1_empty", q0.size(), 0);
        chk("q_rnd0_empty", q1.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/dot_mac.md
# dot_mac

Parametrised, multi-lane fixed-point dot-product engine, successor to the single-lane 3-stage MAC. Each accepted beat multiplies `LANES` signed Qm.FRAC operand pairs, sums them through an adder tree, and accumulates across a framed vector (`in_first` … `in_last`) in a wide accumulator preloaded with a bias. At end of vector, the result is rounded, saturated back to `WIDTH`, and presented on a valid/ready output. It sits between the weight/activation buffers and the activation stage of the linear-layer datapath.

## Interface
- `WIDTH`, 16, operand/result width (signed, two's complement)
- `FRAC`, 10, fractional bits of operands, bias and result (≥1)
- `LANES`, 4, multipliers per beat (power of two, ≥1)
- `ACC_WIDTH`, 40, accumulator width; must be ≥ 2*WIDTH + clog2(LANES) + clog2(max beats per vector)
- `RND`, 1, 1 = round half up at output, 0 = truncate (floor)

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `in_valid` in 1: beat present
- `in_ready` out 1: beat accepted when `in_valid && in_ready`
- `in_first` in 1: beat starts a new vector (loads bias)
- `in_last` in 1: beat ends the vector
- `a`, `b` in LANES*WIDTH: packed signed operands, lane i = bits [i*WIDTH +: WIDTH]
- `bias` in WIDTH: signed Q.FRAC, sampled only on `in_first` beats
- `out_valid` out 1: result present
- `out_ready` in 1: result consumed when `out_valid && out_ready`
- `out_data` out WIDTH: rounded/saturated signed result
- `out_sat` out 1: `out_data` was clipped
- `out_beats` out 16: number of beats in the finished vector (saturates at 65535)

## Operation
- Pipeline: S1 input register → S2 per-lane products (2*WIDTH, 2*FRAC frac bits) → S3 adder tree sum (2*WIDTH+clog2(LANES), sign-extended) → S4 accumulator → S5 output register.
- S4, first beat: `acc = sext(bias) <<< FRAC + sum`; other beats: `acc = acc + sum`. A beat arriving with `in_first=0` after reset or after a `last` accumulates onto 0 (no bias); this is legal.
- `in_first && in_last` on the same beat: single-beat vector.
- Beat counter: 1 on a first beat, +1 otherwise, saturating at 65535; copied into `out_beats` with the result.
- On a `last` beat leaving S4, the rounded/saturated value is loaded into S5:
  - `r = (acc + (RND ? 1<<(FRAC-1) : 0)) >>> FRAC` (floor)
  - Clip `r` to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; `out_sat=1` if clipped.
  - The accumulator and counter clear to 0 in the same cycle.
- Accumulator overflow beyond `ACC_WIDTH` wraps silently; sizing `ACC_WIDTH` correctly is the integrator's responsibility.
- Non-last beats never produce output.

## Timing
- Reset: `out_valid=0`, `out_data=0`, `out_sat=0`, `out_beats=0`, `in_ready=1`. All stage valids, the accumulator and the counter are 0.
- Reset mid-vector: the partial vector and any pending result are discarded. The next beat starts from 0.
- Latency: a `last` beat accepted at edge t gives `out_valid=1` after edge t+4.
- Throughput: one beat per cycle, including back-to-back vectors. The `last` of vector n and the `first` of vector n+1 may be consecutive beats.
- Global stall: `advance = !out_valid || out_ready`; `in_ready = advance` (combinational from `out_ready`). When `advance=0`, all stages, the accumulator and the counter hold.
- While stalled, `out_data`, `out_sat` and `out_beats` are stable and `out_valid` stays high.
- `in_valid=0` inserts a bubble. Bubbles do not disturb the accumulator. `in_first`, `in_last`, `a`, `b` and `bias` are don't-care when `in_valid=0`.
- When a result is consumed and another `last` reaches S5 in the same edge, S5 reloads with the new result and `out_valid` stays 1.

## Structure
- Shared package `mac_pkg` holds:
  - Q-format constants (`WIDTH`, `FRAC` defaults)
  - the `round_sat` function (acc, FRAC, WIDTH, RND → value, sat flag)
  - the clog2-based width helper for tree and accumulator sizing
- One sub-module, `mac_adder_tree`: parametrised `LANES`-input registered signed sum, forming S3.
- Multipliers, accumulator, counter and handshake stay in `dot_mac`.

## Test plan
- Single beat, `first=last=1`, all lanes a=1.0 (1024), b=2.0 (2048), bias 0 → `out_data=8192` (8.0), `out_sat=0`, `out_beats=1`, `out_valid` after edge t+4.
- 3-beat vector, all lanes a=1.5 (1536), b=-0.5 (-512), bias 1.0 (1024) → -9.0+1.0 gives `out_data=-8192`, `out_beats=3`.
- Saturation: all lanes a=b=31.0 (31744), one beat → `out_data=32767`, `out_sat=1`. With b=-31.0 → `out_data=-32768`, `out_sat=1`.
- Rounding: lane0 a=1, b=512, other lanes 0 → `RND=1` gives 1, `RND=0` gives 0. With a=-1 → 0 for `RND=1`, -1 for `RND=0`.
- Backpressure: continuous single-beat vectors with `out_ready` low for 6 cycles:
  - `in_ready` falls while `out_valid && !out_ready`.
  - Output is held stable; no result is lost or duplicated; the order is preserved.
- Reset asserted on beat 2 of a 4-beat vector, then a fresh single-beat vector (a=b=1.0 lane0, bias 0) → only `out_data=1024`, `out_beats=1` appears.
